prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 87 ++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams program words into RAM, then releases the CPU from reset.
// Define LOADER_CHECKSUM_EN to treat the last word as a 16-bit sum of the preceding words.
module prog_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    input  logic          in_last,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [15:0]   ram_w_data,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;
    state_t state, next_state;
    logic [AW-1:0] ptr;
    logic xfer, start, wr, sum_ok, ptr_max;
    assign xfer    = in_valid && in_ready;
    assign start   = load_req && state != LOAD;
    assign ptr_max = &ptr;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
    assign wr     = xfer && !in_last;
    assign sum_ok = in_data == sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (start)
            sum <= '0;
        else if (wr)
            sum <= sum + in_data;
    end
`else
    assign wr     = xfer;
    assign sum_ok = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (state == LOAD) begin
            if (xfer)
                next_state = in_last ? (sum_ok ? RUN : ERR) : (ptr_max ? ERR : LOAD);
        end else if (load_req) begin
            next_state = LOAD;
        end
    end
    // Release waits for the final strobe to clear so the last word lands before the CPU fetches.
    always_comb begin
        in_ready  = state == LOAD;
        done      = state == RUN && !ram_w_en;
        cpu_rst_n = done;
        err       = state == ERR;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_w_en   <= 1'b0;
            ram_w_addr <= '0;
            ram_w_data <= '0;
            ptr        <= '0;
            word_count <= '0;
        end else begin
            ram_w_en <= wr;
            if (start) begin
                ptr        <= base_addr;
                word_count <= '0;
            end else if (wr) begin
                ram_w_addr <= ptr;
                ram_w_data <= in_data;
                ptr        <= ptr_max ? ptr : ptr + AW'(1);
                word_count <= word_count + (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized checks of prog_loader against a stream-level model.
module tb_prog_loader;
    localparam int AW = 8;
    logic          clk = 1'b0, rst_n = 1'b0, load_req = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   in_data = '0;
    logic          in_ready, ram_w_en, cpu_rst_n, done, err;
    logic [AW-1:0] ram_w_addr;
    logic [15:0]   ram_w_data;
    logic [AW:0]   word_count;
    int compared = 0, mismatched = 0;
    logic [AW-1:0] got_a[$], exp_a[$];
    logic [15:0]   got_d[$], exp_d[$];
    logic          exp_err;
    int            exp_cnt;

    prog_loader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && ram_w_en) begin
            got_a.push_back(ram_w_addr);
            got_d.push_back(ram_w_data);
        end

    // Expected RAM image and outcome for one load, from the stream rules alone.
    function automatic void model(input logic [AW-1:0] base, input logic [15:0] w[$]);
        int p = base;
        logic [15:0] s = '0;
        exp_a.delete(); exp_d.delete(); exp_err = 1'b0; exp_cnt = 0;
        for (int i = 0; i < w.size(); i++) begin
            bit last = (i == w.size() - 1);
`ifdef LOADER_CHECKSUM_EN
            if (last) begin exp_err = (w[i] != s); break; end
`endif
            exp_a.push_back(AW'(p)); exp_d.push_back(w[i]); exp_cnt++; s += w[i];
            if (!last && p == (1 << AW) - 1) begin exp_err = 1'b1; break; end
            if (p < (1 << AW) - 1) p++;
        end
    endfunction

    // vmode: 0 back-to-back, 1 toggling valid, 2 random valid; noise drives stray load_req during LOAD.
    task automatic run_load(input logic [AW-1:0] base, input logic [15:0] w[$], input int vmode, input bit noise);
        int i = 0, t = 0;
        bit tog = 1'b1;
        got_a.delete(); got_d.delete();
        @(negedge clk); load_req = 1'b1; base_addr = base;
        @(negedge clk); load_req = 1'b0;
        while (i < w.size() && t < 500) begin
            if (!in_ready) break;
            in_valid  = vmode == 0 ? 1'b1 : vmode == 1 ? tog : 1'($urandom % 2);
            tog       = ~tog;
            in_data   = in_valid ? w[i] : 16'($urandom);
            in_last   = in_valid ? (i == w.size() - 1) : 1'($urandom % 2);
            load_req  = noise && ($urandom % 4 == 0);
            base_addr = AW'($urandom);
            if (in_valid) i++;
            @(negedge clk); t++;
        end
        load_req = 1'b0;
        if (t >= 500) begin
            compared++; mismatched++;
            $display("FAIL load_timeout: stream stalled after %0d of %0d words", i, w.size());
        end
        repeat (3) begin
            in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'($urandom % 2);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        compared++;
        if ({cpu_rst_n, in_ready, ram_w_en, done, err, word_count, ram_w_addr, ram_w_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cpu_rst_n, in_ready, ram_w_en, done, err, word_count, ram_w_addr, ram_w_data});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

`ifndef LOADER_CHECKSUM_EN
    task automatic test_back_to_back;
        logic [15:0] w[3] = '{16'h1111, 16'h2222, 16'h3333};
        @(negedge clk); load_req = 1'b1; base_addr = 8'h10;
        @(negedge clk); load_req = 1'b0;
        compared++;
        if ({in_ready, cpu_rst_n} !== 2'b10) begin
            mismatched++; $display("FAIL b2b_enter_load: got %b want 10", {in_ready, cpu_rst_n});
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = w[i]; in_last = (i == 2);
            @(negedge clk);
            compared++;
            if ({ram_w_en, ram_w_addr, ram_w_data} !== {1'b1, AW'(8'h10 + i), w[i]}) begin
                mismatched++;
                $display("FAIL b2b_write%0d: got %h want %h", i, {ram_w_en, ram_w_addr, ram_w_data},
                         {1'b1, AW'(8'h10 + i), w[i]});
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        compared++;
        if ({word_count, done, cpu_rst_n} !== {9'd3, 2'b00}) begin
            mismatched++; $display("FAIL b2b_last_strobe: got %h want %h", {word_count, done, cpu_rst_n}, {9'd3, 2'b00});
        end
        @(negedge clk);
        compared++;
        if ({ram_w_en, done, cpu_rst_n, err, in_ready, word_count} !== {5'b01100, 9'd3}) begin
            mismatched++;
            $display("FAIL b2b_release: got %h want %h", {ram_w_en, done, cpu_rst_n, err, in_ready, word_count}, {5'b01100, 9'd3});
        end
    endtask
`endif

    task automatic test_toggle;
        logic [15:0] w[$];
        w = {16'h1111, 16'h2222, 16'h3333};
        model(8'h10, w);
        run_load(8'h10, w, 1, 1'b0);
        compared++;
        if (got_a.size() != exp_a.size()) begin
            mismatched++; $display("FAIL toggle_writes: got %0d want %0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            compared++;
            if ({got_a[i], got_d[i]} !== {exp_a[i], exp_d[i]}) begin
                mismatched++; $display("FAIL toggle_write%0d: got %h want %h", i, {got_a[i], got_d[i]}, {exp_a[i], exp_d[i]});
            end
        end
        compared++;
        if ({err, done, cpu_rst_n, word_count} !== {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)}) begin
            mismatched++;
            $display("FAIL toggle_final: got %h want %h", {err, done, cpu_rst_n, word_count}, {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)});
        end
    endtask

    task automatic test_overflow;
        logic [15:0] w[$];
        w = {16'hA001, 16'hA002, 16'hA003};
        run_load(8'hFE, w, 0, 1'b0);
        compared++;
        if (got_a.size() != 2) begin
            mismatched++; $display("FAIL ovf_writes: got %0d want 2", got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 2; i++) begin
            compared++;
            if ({got_a[i], got_d[i]} !== {AW'(8'hFE + i), w[i]}) begin
                mismatched++; $display("FAIL ovf_write%0d: got %h want %h", i, {got_a[i], got_d[i]}, {AW'(8'hFE + i), w[i]});
            end
        end
        compared++;
        if ({err, done, cpu_rst_n, in_ready, word_count} !== {4'b1000, 9'd2}) begin
            mismatched++; $display("FAIL ovf_final: got %h want %h", {err, done, cpu_rst_n, in_ready, word_count}, {4'b1000, 9'd2});
        end
    endtask

    task automatic test_reset_mid_load;
        logic [15:0] w[$];
        @(negedge clk); load_req = 1'b1; base_addr = 8'h40;
        @(negedge clk); load_req = 1'b0; in_valid = 1'b1; in_data = 16'h0BAD; in_last = 1'b0;
        @(negedge clk); in_data = 16'h0BAE;
        @(negedge clk); in_data = 16'h0BAF; rst_n = 1'b0;
        #1;
        compared++;
        if ({cpu_rst_n, in_ready, ram_w_en, done, err, word_count, ram_w_addr, ram_w_data} !== '0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got %h want 0", {cpu_rst_n, in_ready, ram_w_en, done, err, word_count, ram_w_addr, ram_w_data});
        end
        @(posedge clk); #1;
        compared++;
        if ({ram_w_en, in_ready} !== 2'b00) begin
            mismatched++; $display("FAIL midrst_no_strobe: got %b want 00", {ram_w_en, in_ready});
        end
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
        w = {16'h1234, 16'h5678, 16'h9ABC};
        model(8'h00, w);
        run_load(8'h00, w, 0, 1'b0);
        compared++;
        if (got_a.size() != exp_a.size()) begin
            mismatched++; $display("FAIL midrst_reload_writes: got %0d want %0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            compared++;
            if ({got_a[i], got_d[i]} !== {exp_a[i], exp_d[i]}) begin
                mismatched++; $display("FAIL midrst_write%0d: got %h want %h", i, {got_a[i], got_d[i]}, {exp_a[i], exp_d[i]});
            end
        end
        compared++;
        if ({err, done, cpu_rst_n, word_count} !== {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)}) begin
            mismatched++;
            $display("FAIL midrst_final: got %h want %h", {err, done, cpu_rst_n, word_count}, {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)});
        end
    endtask

    task automatic test_checksum;
        logic [15:0] w[$];
        for (int k = 0; k < 2; k++) begin
            w = {16'h0001, 16'h0002, 16'(3 + k)};
            model(8'h20, w);
            run_load(8'h20, w, 0, 1'b0);
            compared++;
            if (got_a.size() != exp_a.size()) begin
                mismatched++; $display("FAIL csum%0d_writes: got %0d want %0d", k, got_a.size(), exp_a.size());
            end
            for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
                compared++;
                if ({got_a[i], got_d[i]} !== {exp_a[i], exp_d[i]}) begin
                    mismatched++; $display("FAIL csum%0d_write%0d: got %h want %h", k, i, {got_a[i], got_d[i]}, {exp_a[i], exp_d[i]});
                end
            end
            compared++;
            if ({err, done, cpu_rst_n, word_count} !== {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)}) begin
                mismatched++;
                $display("FAIL csum%0d_final: got %h want %h", k, {err, done, cpu_rst_n, word_count}, {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)});
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] w[$];
        logic [15:0] s;
        logic [AW-1:0] b;
        int n;
        for (int k = 0; k < 40; k++) begin
            w.delete(); s = '0;
            n = 1 + $urandom % 6;
            b = ($urandom % 4 == 0) ? AW'(8'hF8 + $urandom % 8) : AW'($urandom);
            for (int i = 0; i < n; i++) begin
                w.push_back(16'($urandom));
                if (i < n - 1) s += w[i];
            end
`ifdef LOADER_CHECKSUM_EN
            if ($urandom % 2 == 0) w[n-1] = s;
`endif
            model(b, w);
            run_load(b, w, $urandom % 3, 1'b1);
            compared++;
            if (got_a.size() != exp_a.size()) begin
                mismatched++; $display("FAIL rand%0d_writes: got %0d want %0d", k, got_a.size(), exp_a.size());
            end
            for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
                compared++;
                if ({got_a[i], got_d[i]} !== {exp_a[i], exp_d[i]}) begin
                    mismatched++; $display("FAIL rand%0d_write%0d: got %h want %h", k, i, {got_a[i], got_d[i]}, {exp_a[i], exp_d[i]});
                end
            end
            compared++;
            if ({err, done, cpu_rst_n, word_count} !== {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)}) begin
                mismatched++;
                $display("FAIL rand%0d_final: got %h want %h", k, {err, done, cpu_rst_n, word_count}, {exp_err, !exp_err, !exp_err, (AW+1)'(exp_cnt)});
            end
        end
    endtask

    initial begin
        test_reset;
`ifndef LOADER_CHECKSUM_EN
        test_back_to_back;
`endif
        test_toggle;
        test_overflow;
        test_reset_mid_load;
        test_checksum;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
